// File: rtl/ghost_collision_detector.sv
// Frame-accumulated ghost overlap detector with frame-based cooldown.
// Optional saturating pulse counter when GHOST_HIT_CNT_EN is defined.
module ghost_collision_detector #(
  parameter int unsigned COOLDOWN_FRAMES = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             drawReq_ghost,
  input  logic             drawReq_border,
  input  logic             drawReq_player,
`ifdef GHOST_HIT_CNT_EN
  output logic [CNT_W-1:0] hit_count,
`endif
  output logic             collision,
  output logic             hit_border,
  output logic             hit_player
);

  localparam int unsigned CdW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic {StArmed, StCooldown} state_e;

  state_e         state_q, state_d;
  logic           fb_q, fb_d, fp_q, fp_d;
  logic [CdW-1:0] cd_q, cd_d;
  logic           hb_q, hb_d, hp_q, hp_d;
  logic           ob, op;

  assign ob = drawReq_ghost & drawReq_border;
  assign op = drawReq_ghost & drawReq_player;

  always_comb begin
    state_d = state_q;
    fb_d    = fb_q;
    fp_d    = fp_q;
    cd_d    = cd_q;
    hb_d    = 1'b0;
    hp_d    = 1'b0;
    unique case (state_q)
      StArmed: begin
        if (!startOfFrame) begin
          fb_d = fb_q | ob;
          fp_d = fp_q | op;
        end else if (fb_q | fp_q) begin
          hb_d = fb_q;
          hp_d = fp_q;
          fb_d = 1'b0;
          fp_d = 1'b0;
          if (COOLDOWN_FRAMES > 0) begin
            cd_d    = CdW'(COOLDOWN_FRAMES);
            state_d = StCooldown;
          end
        end else begin
          // Overlap in the boundary cycle belongs to the new frame.
          fb_d = ob;
          fp_d = op;
        end
      end
      StCooldown: begin
        fb_d = 1'b0;
        fp_d = 1'b0;
        if (startOfFrame) begin
          cd_d = cd_q - CdW'(1);
          if (cd_q == CdW'(1)) begin
            state_d = StArmed;
            fb_d    = ob;
            fp_d    = op;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StArmed;
      fb_q    <= 1'b0;
      fp_q    <= 1'b0;
      cd_q    <= '0;
      hb_q    <= 1'b0;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      fp_q    <= fp_d;
      cd_q    <= cd_d;
      hb_q    <= hb_d;
      hp_q    <= hp_d;
    end
  end

  assign hit_border = hb_q;
  assign hit_player = hp_q;
  assign collision  = hb_q | hp_q;

`ifdef GHOST_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts alongside the pulse register so the new value appears with collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((hb_d | hp_d) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_count = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ghost_collision_detector.sv
// Self-checking bench for ghost_collision_detector (COOLDOWN_FRAMES=2, CNT_W=2).
module tb_ghost_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       drawReq_ghost = 1'b0;
  logic       drawReq_border = 1'b0;
  logic       drawReq_player = 1'b0;
  logic       collision, hit_border, hit_player;
`ifdef GHOST_HIT_CNT_EN
  logic [1:0] hit_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Expected {collision, hit_border, hit_player} after each driven edge.
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  ghost_collision_detector #(
    .COOLDOWN_FRAMES(2),
    .CNT_W          (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .drawReq_ghost (drawReq_ghost),
    .drawReq_border(drawReq_border),
    .drawReq_player(drawReq_player),
`ifdef GHOST_HIT_CNT_EN
    .hit_count     (hit_count),
`endif
    .collision     (collision),
    .hit_border    (hit_border),
    .hit_player    (hit_player)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs, push expectation, then pop and compare after the edge.
  task automatic cyc(input string tag, input logic rst, input logic sof, input logic g,
                     input logic b, input logic p, input logic [2:0] exp);
    logic [2:0] e;
    reset          = rst;
    startOfFrame   = sof;
    drawReq_ghost  = g;
    drawReq_border = b;
    drawReq_player = p;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, {5'b0, collision, hit_border, hit_player}, {5'b0, e});
  endtask

  task automatic idle(input string tag, input int n, input logic g, input logic b,
                      input logic p);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, g, b, p, 3'b000);
  endtask

  initial begin
    // Reset held for two cycles.
    cyc("reset0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
    cyc("reset1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
`ifdef GHOST_HIT_CNT_EN
    check_eq("reset_count", {6'b0, hit_count}, 8'd0);
`endif

    // Border hit: 5 overlap cycles, then boundary -> single pulse.
    idle("bh_pre", 3, 1'b0, 1'b0, 1'b0);
    idle("bh_ov", 5, 1'b1, 1'b1, 1'b0);
    cyc("bh_sof", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
    idle("bh_after", 2, 1'b0, 1'b0, 1'b0);

    // Cooldown: overlap every frame -> pulses at boundaries 1, 4, 7.
    cyc("cd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int f = 1; f <= 7; f++) begin
      idle("cd_ov", 4, 1'b1, 1'b1, 1'b0);
      cyc("cd_sof", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
          (f == 1 || f == 4 || f == 7) ? 3'b110 : 3'b000);
    end
    idle("cd_after", 1, 1'b0, 1'b0, 1'b0);

    // Both causes in one frame.
    cyc("both_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle("both_b", 2, 1'b1, 1'b1, 1'b0);
    idle("both_n", 2, 1'b0, 1'b1, 1'b1);
    idle("both_p", 2, 1'b1, 1'b0, 1'b1);
    cyc("both_sof", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111);
    idle("both_after", 1, 1'b0, 1'b0, 1'b0);

    // Overlap only in the boundary cycle counts for the next frame.
    cyc("bnd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle("bnd_pre", 3, 1'b0, 1'b0, 1'b0);
    cyc("bnd_sof1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    idle("bnd_mid", 3, 1'b0, 1'b0, 1'b0);
    cyc("bnd_sof2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);

    // Reset mid-frame discards pending flags.
    cyc("rmf_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle("rmf_ov", 3, 1'b1, 1'b0, 1'b1);
    cyc("rmf_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    cyc("rmf_sof", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    idle("rmf_after", 1, 1'b0, 1'b0, 1'b0);

    // Back-to-back boundaries through cooldown; re-arming boundary captures its overlap.
    cyc("b2b_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle("b2b_ov", 2, 1'b1, 1'b1, 1'b0);
    cyc("b2b_sof1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110);
    cyc("b2b_sof2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    cyc("b2b_sof3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
    cyc("b2b_sof4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
    idle("b2b_after", 1, 1'b0, 1'b0, 1'b0);

`ifdef GHOST_HIT_CNT_EN
    // Saturation: five pulses with a 2-bit counter.
    cyc("sat_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    check_eq("sat_zero", {6'b0, hit_count}, 8'd0);
    for (int k = 0; k < 5; k++) begin
      idle("sat_ov", 2, 1'b1, 1'b1, 1'b0);
      cyc("sat_sof", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
      check_eq("sat_count", {6'b0, hit_count}, (k < 3) ? 8'(k + 1) : 8'd3);
      cyc("sat_cd1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      cyc("sat_cd2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    end
    check_eq("sat_final", {6'b0, hit_count}, 8'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
